// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: edge/level capture, masking and
// single-outstanding delivery to the CPU with end-of-interrupt handshake.
module irq_controller #(
    parameter int NUM_IRQS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQS-1:0] irq_sources,
    input  logic [NUM_IRQS-1:0] irq_mask,
    input  logic [NUM_IRQS-1:0] irq_edge_sel,
    input  logic [NUM_IRQS-1:0] clr_vec,
    input  logic                eoi,
    output logic                irq_out,
    output logic [2:0]          active_id,
    output logic [NUM_IRQS-1:0] pending,
    output logic [NUM_IRQS-1:0] overflow
);

    typedef enum logic {
        IDLE,
        ASSERT
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          id_q, id_d, win_id;
    logic [NUM_IRQS-1:0] src_d, pend_q, pend_d, ovf_q, ovf_d;
    logic [NUM_IRQS-1:0] edge_ev, eoi_hit, cand;
    logic                keep;

    always_comb begin
        edge_ev = irq_sources & ~src_d;
        eoi_hit = '0;
        pend_d  = pend_q;
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (state_q == ASSERT && eoi && id_q == 3'(i))
                eoi_hit[i] = 1'b1;
        end
        // Set beats clear in edge mode; level mode simply follows the line.
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (irq_edge_sel[i])
                pend_d[i] = edge_ev[i] | (pend_q[i] & ~(clr_vec[i] | eoi_hit[i]));
            else
                pend_d[i] = irq_sources[i];
        end
        ovf_d = (edge_ev & pend_q & irq_edge_sel) | (ovf_q & ~clr_vec);
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cand    = pend_q & irq_mask;
        win_id  = 3'd7;
        keep    = 1'b0;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (cand[i])
                win_id = 3'(i);
        end
        // Look at next-cycle pending so a clear withdraws one cycle later.
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (id_q == 3'(i))
                keep = pend_d[i] & irq_mask[i];
        end
        unique case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = ASSERT;
                    id_d    = win_id;
                end
            end
            ASSERT: begin
                if (eoi || !keep)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_out   = (state_q == ASSERT);
        active_id = (state_q == ASSERT) ? id_q : 3'd7;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 3'd7;
            src_d   <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            src_d   <= irq_sources;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed vector bench for irq_controller: a table of per-cycle inputs and
// expected outputs, plus hand sequences for async reset and reset release.
module tb_irq_controller;

    logic       clk;
    logic       rst;
    logic [3:0] irq_sources;
    logic [3:0] irq_mask;
    logic [3:0] irq_edge_sel;
    logic [3:0] clr_vec;
    logic       eoi;
    logic       irq_out;
    logic [2:0] active_id;
    logic [3:0] pending;
    logic [3:0] overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] src;
        logic [3:0] mask;
        logic [3:0] esel;
        logic [3:0] clr;
        logic       eoi;
        logic       x_irq;
        logic [2:0] x_id;
        logic [3:0] x_pend;
        logic [3:0] x_ovf;
    } vec_t;

    vec_t vecs[$];

    irq_controller #(.NUM_IRQS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_sources  (irq_sources),
        .irq_mask     (irq_mask),
        .irq_edge_sel (irq_edge_sel),
        .clr_vec      (clr_vec),
        .eoi          (eoi),
        .irq_out      (irq_out),
        .active_id    (active_id),
        .pending      (pending),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_all(input int row, input logic x_irq,
                             input logic [2:0] x_id, input logic [3:0] x_pend,
                             input logic [3:0] x_ovf);
        chk("irq_out", row, {7'd0, irq_out}, {7'd0, x_irq});
        chk("active_id", row, {5'd0, active_id}, {5'd0, x_id});
        chk("pending", row, {4'd0, pending}, {4'd0, x_pend});
        chk("overflow", row, {4'd0, overflow}, {4'd0, x_ovf});
    endtask

    task automatic add(input logic [3:0] src, input logic [3:0] mask,
                       input logic [3:0] esel, input logic [3:0] clr,
                       input logic e, input logic xi, input logic [2:0] xid,
                       input logic [3:0] xp, input logic [3:0] xo);
        vec_t v;
        v.src = src; v.mask = mask; v.esel = esel; v.clr = clr; v.eoi = e;
        v.x_irq = xi; v.x_id = xid; v.x_pend = xp; v.x_ovf = xo;
        vecs.push_back(v);
    endtask

    initial begin
        // priority and eoi
        add(4'b0110, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0110, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd1, 4'b0110, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd1, 4'b0110, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 1, 0, 3'd7, 4'b0100, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd2, 4'b0100, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 1, 0, 3'd7, 4'b0000, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0000, 4'h0);
        // masking
        add(4'b1000, 4'h7, 4'hF, 4'h0, 0, 0, 3'd7, 4'b1000, 4'h0);
        add(4'b0000, 4'h7, 4'hF, 4'h0, 0, 0, 3'd7, 4'b1000, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd3, 4'b1000, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 1, 0, 3'd7, 4'b0000, 4'h0);
        // withdraw by clear
        add(4'b0001, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0001, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd0, 4'b0001, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h1, 0, 0, 3'd7, 4'b0000, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0000, 4'h0);
        // overflow and eoi/edge collision
        add(4'b0010, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0010, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd1, 4'b0010, 4'h0);
        add(4'b0010, 4'hF, 4'hF, 4'h0, 0, 1, 3'd1, 4'b0010, 4'b0010);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd1, 4'b0010, 4'b0010);
        add(4'b0010, 4'hF, 4'hF, 4'h0, 1, 0, 3'd7, 4'b0010, 4'b0010);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd1, 4'b0010, 4'b0010);
        add(4'b0000, 4'hF, 4'hF, 4'h2, 0, 0, 3'd7, 4'b0000, 4'h0);
        // withdraw by mask drop
        add(4'b0001, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0001, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd0, 4'b0001, 4'h0);
        add(4'b0000, 4'hE, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0001, 4'h0);
        add(4'b0000, 4'hE, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0001, 4'h0);
        add(4'b0000, 4'hE, 4'hF, 4'h1, 0, 0, 3'd7, 4'b0000, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0000, 4'h0);
        // level mode on source 0, then switch back to edge
        add(4'b0001, 4'hF, 4'hE, 4'h0, 0, 0, 3'd7, 4'b0001, 4'h0);
        add(4'b0001, 4'hF, 4'hE, 4'h0, 0, 1, 3'd0, 4'b0001, 4'h0);
        add(4'b0001, 4'hF, 4'hE, 4'h0, 1, 0, 3'd7, 4'b0001, 4'h0);
        add(4'b0001, 4'hF, 4'hE, 4'h0, 0, 1, 3'd0, 4'b0001, 4'h0);
        add(4'b0000, 4'hF, 4'hE, 4'h0, 0, 0, 3'd7, 4'b0000, 4'h0);
        add(4'b0001, 4'hF, 4'hE, 4'h0, 0, 0, 3'd7, 4'b0001, 4'h0);
        add(4'b0001, 4'hF, 4'hF, 4'h0, 0, 1, 3'd0, 4'b0001, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd0, 4'b0001, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 1, 0, 3'd7, 4'b0000, 4'h0);
        // reach ASSERT on source 2 ahead of async reset
        add(4'b0100, 4'hF, 4'hF, 4'h0, 0, 0, 3'd7, 4'b0100, 4'h0);
        add(4'b0000, 4'hF, 4'hF, 4'h0, 0, 1, 3'd2, 4'b0100, 4'h0);

        rst = 1'b1;
        irq_sources = '0;
        irq_mask = 4'hF;
        irq_edge_sel = 4'hF;
        clr_vec = '0;
        eoi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 0, 3'd7, 4'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            irq_sources  = vecs[i].src;
            irq_mask     = vecs[i].mask;
            irq_edge_sel = vecs[i].esel;
            clr_vec      = vecs[i].clr;
            eoi          = vecs[i].eoi;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].x_irq, vecs[i].x_id,
                      vecs[i].x_pend, vecs[i].x_ovf);
            @(negedge clk);
        end

        // async reset mid-ASSERT, no clock edge in between
        irq_sources = '0;
        clr_vec = '0;
        eoi = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_all(100, 0, 3'd7, 4'h0, 4'h0);

        // source already high at reset release counts as one edge
        irq_sources = 4'b0001;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all(101, 0, 3'd7, 4'b0001, 4'h0);
        @(posedge clk);
        #1;
        check_all(102, 1, 3'd0, 4'b0001, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
